// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Encodes a stream of instruction-field beats into RV32I words and writes them
// sequentially into instruction memory, starting at word 0 for every session.
// Supported classes: LOAD, STORE, R-type, BRANCH, I-type ALU (incl. shifts), JAL.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   start             : opens a new session from IDLE/DONE/ERR (ignored in LOAD)
//   in_valid/in_ready : beat handshake; ready is high only while loading
//   in_type .. in_last: instruction fields of the beat
//   imem_we/addr/wdata: registered imem write port, one cycle after acceptance
//   busy, done        : session in progress / session finished cleanly
//   err_code          : 00 none, 01 illegal type, 10 imm out of range, 11 overflow
//   count             : words written during the current session
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TYPE  = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [1:0]          err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  // ---------------------------------------------------------------------------
  // Immediate range checks, done on bit patterns rather than signed compares:
  // a value fits an N-bit signed field when all bits above N-2 agree in sign.
  // ---------------------------------------------------------------------------
  logic is_shift;
  logic imm12_ok;
  logic shamt_ok;
  logic branch_ok;
  logic jal_ok;

  assign is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign imm12_ok  = (in_imm[20:11] == '0) || (in_imm[20:11] == '1);
  assign shamt_ok  = (in_imm[20:5] == '0);
  assign branch_ok = ((in_imm[20:12] == '0) || (in_imm[20:12] == '1)) && !in_imm[0];
  assign jal_ok    = !in_imm[0];

  // ---------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        type_ok;
  logic        range_ok;

  always_comb begin
    enc_word = 32'h0;
    type_ok  = 1'b1;
    range_ok = 1'b1;
    case (in_type)
      3'd0: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        range_ok = imm12_ok;
      end
      3'd1: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        range_ok = imm12_ok;
      end
      3'd2: begin
        enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
      end
      3'd3: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
        range_ok = branch_ok;
      end
      3'd4: begin
        if (is_shift) begin
          // Shifts carry funct7 in the upper immediate bits; only shamt is taken.
          enc_word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
          range_ok = shamt_ok;
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
          range_ok = imm12_ok;
        end
      end
      3'd5: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        range_ok = jal_ok;
      end
      default: begin
        type_ok = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Session control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (!type_ok) begin
            err_d   = ERR_TYPE;
            state_d = S_ERR;
          end else if (!range_ok) begin
            err_d   = ERR_RANGE;
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_q + 1'b1;
            if (in_last) begin
              state_d = S_DONE;
            end else if (count_q[ADDR_W-1:0] == '1) begin
              // Last word of imem written but the session wants more.
              err_d   = ERR_OVF;
              state_d = S_ERR;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          addr_d  = '0;
          err_d   = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err_code   = err_q;
  assign count      = count_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
